// File: rtl/pattern_sequencer.sv
// pattern_sequencer: per-frame mode, palette rotation and bouncing-box control.
// Optional macro AUTO_CYCLE_EN advances the mode automatically every AUTO_FRAMES ticks.
module pattern_sequencer #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int H_MIN           = 143,
  parameter int H_MAX           = 783,
  parameter int V_MIN           = 35,
  parameter int V_MAX           = 515,
  parameter int BOX_W           = 80,
  parameter int BOX_H           = 60,
  parameter int STEP            = 2,
  parameter int FRAME_DIV       = 4
`ifdef AUTO_CYCLE_EN
  ,
  parameter int AUTO_FRAMES     = 300
`endif
) (
  input  logic        clkin,
  input  logic        reset_n,
  input  logic [15:0] hValue,
  input  logic [15:0] vValue,
  input  logic        pbutton,
  output logic        frame_tick,
  output logic [1:0]  mode,
  output logic [5:0]  rot_offset,
  output logic        box_en,
  output logic [15:0] box_hmin,
  output logic [15:0] box_hmax,
  output logic [15:0] box_vmin,
  output logic [15:0] box_vmax
);

  typedef enum logic [1:0] {
    STATIC     = 2'd0,
    ROTATE     = 2'd1,
    BOUNCE     = 2'd2,
    ROT_BOUNCE = 2'd3
  } mode_t;

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int FW = $clog2(FRAME_DIV + 1);

  logic          sync1, sync2, db_level;
  logic [DW-1:0] db_cnt;
  logic          db_flip, press, auto_hit;

  mode_t         state_q, state_n;
  logic          pend_q, pend_n;
  logic [FW-1:0] fc_q, fc_n;
  logic [5:0]    rot_n;
  logic [15:0]   hmin_n, vmin_n;
  logic          fh_q, fh_n, fv_q, fv_n;
  logic          step;

  assign db_flip = (sync2 != db_level) &&
                   (db_cnt == DW'(DEBOUNCE_CYCLES - 1));
  assign press   = db_flip && !sync2;

  always_ff @(posedge clkin or negedge reset_n) begin
    if (!reset_n) begin
      sync1    <= 1'b1;
      sync2    <= 1'b1;
      db_level <= 1'b1;
      db_cnt   <= '0;
    end else begin
      sync1 <= pbutton;
      sync2 <= sync1;
      if (sync2 == db_level) begin
        db_cnt <= '0;
      end else if (db_flip) begin
        db_cnt   <= '0;
        db_level <= sync2;
      end else begin
        db_cnt <= db_cnt + DW'(1);
      end
    end
  end

`ifdef AUTO_CYCLE_EN
  localparam int AW = $clog2(AUTO_FRAMES + 1);
  logic [AW-1:0] auto_q, auto_n;

  // Pending is raised one tick early so the change lands on the AUTO_FRAMES-th tick.
  always_comb begin
    auto_n   = auto_q;
    auto_hit = 1'b0;
    if (frame_tick) begin
      if (pend_q) begin
        auto_n = '0;
      end else begin
        auto_n   = auto_q + AW'(1);
        auto_hit = (auto_n == AW'(AUTO_FRAMES - 1));
      end
    end
  end

  always_ff @(posedge clkin or negedge reset_n) begin
    if (!reset_n) auto_q <= '0;
    else          auto_q <= auto_n;
  end
`else
  assign auto_hit = 1'b0;
`endif

  always_comb begin
    state_n = state_q;
    pend_n  = pend_q;
    fc_n    = fc_q;
    rot_n   = rot_offset;
    hmin_n  = box_hmin;
    vmin_n  = box_vmin;
    fh_n    = fh_q;
    fv_n    = fv_q;
    step    = 1'b0;
    if (frame_tick) begin
      if (pend_q) begin
        unique case (state_q)
          STATIC:     state_n = ROTATE;
          ROTATE:     state_n = BOUNCE;
          BOUNCE:     state_n = ROT_BOUNCE;
          ROT_BOUNCE: state_n = STATIC;
        endcase
        pend_n = 1'b0;
        fc_n   = '0;
        if (state_q == ROT_BOUNCE) begin
          rot_n  = '0;
          hmin_n = 16'(H_MIN);
          vmin_n = 16'(V_MIN);
          fh_n   = 1'b1;
          fv_n   = 1'b1;
        end
      end else if (fc_q == FW'(FRAME_DIV - 1)) begin
        fc_n = '0;
        step = 1'b1;
      end else begin
        fc_n = fc_q + FW'(1);
      end
    end
    // A press on the tick cycle survives the clear above.
    if (press || auto_hit) pend_n = 1'b1;
    if (step && state_q[0]) rot_n = rot_offset + 6'd8;
    if (step && state_q[1]) begin
      if (fh_q) begin
        if (box_hmin + 16'(STEP + BOX_W) > 16'(H_MAX)) begin
          hmin_n = 16'(H_MAX - BOX_W);
          fh_n   = 1'b0;
        end else begin
          hmin_n = box_hmin + 16'(STEP);
        end
      end else if (box_hmin < 16'(H_MIN + STEP)) begin
        hmin_n = 16'(H_MIN);
        fh_n   = 1'b1;
      end else begin
        hmin_n = box_hmin - 16'(STEP);
      end
      if (fv_q) begin
        if (box_vmin + 16'(STEP + BOX_H) > 16'(V_MAX)) begin
          vmin_n = 16'(V_MAX - BOX_H);
          fv_n   = 1'b0;
        end else begin
          vmin_n = box_vmin + 16'(STEP);
        end
      end else if (box_vmin < 16'(V_MIN + STEP)) begin
        vmin_n = 16'(V_MIN);
        fv_n   = 1'b1;
      end else begin
        vmin_n = box_vmin - 16'(STEP);
      end
    end
  end

  always_ff @(posedge clkin or negedge reset_n) begin
    if (!reset_n) begin
      frame_tick <= 1'b0;
      state_q    <= STATIC;
      pend_q     <= 1'b0;
      fc_q       <= '0;
      rot_offset <= '0;
      box_hmin   <= 16'(H_MIN);
      box_hmax   <= 16'(H_MIN + BOX_W);
      box_vmin   <= 16'(V_MIN);
      box_vmax   <= 16'(V_MIN + BOX_H);
      fh_q       <= 1'b1;
      fv_q       <= 1'b1;
    end else begin
      frame_tick <= (hValue == 16'd0) && (vValue == 16'(V_MAX));
      state_q    <= state_n;
      pend_q     <= pend_n;
      fc_q       <= fc_n;
      rot_offset <= rot_n;
      box_hmin   <= hmin_n;
      box_hmax   <= hmin_n + 16'(BOX_W);
      box_vmin   <= vmin_n;
      box_vmax   <= vmin_n + 16'(BOX_H);
      fh_q       <= fh_n;
      fv_q       <= fv_n;
    end
  end

  assign mode   = state_q;
  assign box_en = state_q[1];

endmodule
